mem_ctrl: RTL and testbench

Memory controller between the core and the single byte-wide RAM/IO bus. It arbitrates two clients: the instruction fetcher (word reads) and the load/store buffer (1/2/4-byte reads and writes). It serialises each access into consecutive byte cycles and assembles or splits data little-endian. It returns a one-cycle completion pulse to the requester and sits directly upstream of the fetcher's memory port.

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, state encodings and access-size helpers for mem_ctrl
package mem_ctrl_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;
    localparam int INS_LEN  = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // addr[17:16] value that selects the memory-mapped IO region
    localparam logic [1:0] IO_REGION = 2'b11;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates fetcher and load/store buffer onto the byte-wide RAM/IO bus
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                io_buffer_full,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [ADDR_LEN-1:0] mem_a,
    output logic                mem_wr,
    input  logic                ena_from_if,
    input  logic [ADDR_LEN-1:0] pc_from_if,
    output logic                ok_flag_to_if,
    output logic [INS_LEN-1:0]  inst_to_if,
    input  logic                ena_from_lsb,
    input  logic                wr_from_lsb,
    input  logic [ADDR_LEN-1:0] addr_from_lsb,
    input  logic [1:0]          size_from_lsb,
    input  logic [DATA_LEN-1:0] data_from_lsb,
    output logic                ok_flag_to_lsb,
    output logic [DATA_LEN-1:0] data_to_lsb,
    input  logic                rollback
);

    state_t              state, state_n;
    logic [2:0]          cnt, cnt_n, len, len_n;
    logic                owner_lsb, owner_lsb_n;
    logic [ADDR_LEN-1:0] addr_q, addr_n;
    logic [DATA_LEN-1:0] data_q, data_n, res, res_n;
    logic                pending_if, pending_if_n, pending_lsb, pending_lsb_n;
    logic [ADDR_LEN-1:0] pc_q, pc_n, lsb_addr_q, lsb_addr_n;
    logic                lsb_wr_q, lsb_wr_n;
    logic [1:0]          lsb_size_q, lsb_size_n;
    logic [DATA_LEN-1:0] lsb_data_q, lsb_data_n;
    logic [7:0]          mem_dout_n;
    logic [ADDR_LEN-1:0] mem_a_n;
    logic                mem_wr_n, ok_if_n, ok_lsb_n;
    logic [INS_LEN-1:0]  inst_n;
    logic [DATA_LEN-1:0] data_lsb_n;

    logic                req_if_new, req_lsb_new, if_v, lsb_v, io_stall;
    logic [1:0]          byte_sel;
    logic [DATA_LEN-1:0] res_merged, wr_word;

    always_comb begin
        // a rollback drops every read request, old or new; stores survive it
        req_if_new  = ena_from_if & ~rollback;
        req_lsb_new = ena_from_lsb & (~rollback | wr_from_lsb);
        if_v        = req_if_new | (pending_if & ~rollback);
        lsb_v       = req_lsb_new | (pending_lsb & (~rollback | lsb_wr_q));
        pc_n        = req_if_new  ? pc_from_if    : pc_q;
        lsb_wr_n    = req_lsb_new ? wr_from_lsb   : lsb_wr_q;
        lsb_addr_n  = req_lsb_new ? addr_from_lsb : lsb_addr_q;
        lsb_size_n  = req_lsb_new ? size_from_lsb : lsb_size_q;
        lsb_data_n  = req_lsb_new ? data_from_lsb : lsb_data_q;
        io_stall    = lsb_wr_n & (lsb_addr_n[17:16] == IO_REGION) & io_buffer_full;

        // byte presented at edge k arrives two edges later
        byte_sel    = cnt[1:0] - 2'd2;
        res_merged  = res | ({24'd0, mem_din} << {byte_sel, 3'b000});
        wr_word     = data_q >> {cnt[1:0], 3'b000};

        pending_if_n  = if_v;
        pending_lsb_n = lsb_v;
        state_n       = state;
        cnt_n         = cnt;
        len_n         = len;
        owner_lsb_n   = owner_lsb;
        addr_n        = addr_q;
        data_n        = data_q;
        res_n         = res;
        mem_dout_n    = mem_dout;
        mem_a_n       = mem_a;
        mem_wr_n      = mem_wr;
        ok_if_n       = FALSE;
        ok_lsb_n      = FALSE;
        inst_n        = inst_to_if;
        data_lsb_n    = data_to_lsb;

        case (state)
            IDLE: begin
                // a stalled IO store still owns the bus; the fetcher waits behind it
                if (lsb_v && !io_stall) begin
                    pending_lsb_n = FALSE;
                    owner_lsb_n   = TRUE;
                    addr_n        = lsb_addr_n;
                    data_n        = lsb_data_n;
                    len_n         = size_to_len(lsb_size_n);
                    mem_a_n       = lsb_addr_n;
                    cnt_n         = 3'd1;
                    res_n         = '0;
                    if (lsb_wr_n) begin
                        mem_dout_n = lsb_data_n[7:0];
                        mem_wr_n   = TRUE;
                        state_n    = WRITE;
                    end else begin
                        mem_wr_n   = FALSE;
                        state_n    = READ;
                    end
                end else if (!lsb_v && if_v) begin
                    pending_if_n = FALSE;
                    owner_lsb_n  = FALSE;
                    addr_n       = pc_n;
                    len_n        = 3'd4;
                    mem_a_n      = pc_n;
                    mem_wr_n     = FALSE;
                    cnt_n        = 3'd1;
                    res_n        = '0;
                    state_n      = READ;
                end
            end
            READ: begin
                if (rollback) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n = cnt + 3'd1;
                    if (cnt < len)
                        mem_a_n = addr_q + 32'(cnt);
                    if (cnt >= 3'd2)
                        res_n = res_merged;
                    if (cnt == len + 3'd1) begin
                        state_n = IDLE;
                        cnt_n   = 3'd0;
                        if (owner_lsb) begin
                            ok_lsb_n   = TRUE;
                            data_lsb_n = res_merged;
                        end else begin
                            ok_if_n    = TRUE;
                            inst_n     = res_merged;
                        end
                    end
                end
            end
            WRITE: begin
                if (cnt < len) begin
                    mem_a_n    = addr_q + 32'(cnt);
                    mem_dout_n = wr_word[7:0];
                    mem_wr_n   = TRUE;
                    cnt_n      = cnt + 3'd1;
                end else begin
                    mem_wr_n = FALSE;
                    ok_lsb_n = TRUE;
                    state_n  = IDLE;
                    cnt_n    = 3'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            len            <= 3'd0;
            owner_lsb      <= FALSE;
            addr_q         <= '0;
            data_q         <= '0;
            res            <= '0;
            pending_if     <= FALSE;
            pending_lsb    <= FALSE;
            pc_q           <= '0;
            lsb_wr_q       <= FALSE;
            lsb_addr_q     <= '0;
            lsb_size_q     <= 2'd0;
            lsb_data_q     <= '0;
            mem_dout       <= 8'd0;
            mem_a          <= '0;
            mem_wr         <= FALSE;
            ok_flag_to_if  <= FALSE;
            ok_flag_to_lsb <= FALSE;
            inst_to_if     <= '0;
            data_to_lsb    <= '0;
        end else if (rdy) begin
            state          <= state_n;
            cnt            <= cnt_n;
            len            <= len_n;
            owner_lsb      <= owner_lsb_n;
            addr_q         <= addr_n;
            data_q         <= data_n;
            res            <= res_n;
            pending_if     <= pending_if_n;
            pending_lsb    <= pending_lsb_n;
            pc_q           <= pc_n;
            lsb_wr_q       <= lsb_wr_n;
            lsb_addr_q     <= lsb_addr_n;
            lsb_size_q     <= lsb_size_n;
            lsb_data_q     <= lsb_data_n;
            mem_dout       <= mem_dout_n;
            mem_a          <= mem_a_n;
            mem_wr         <= mem_wr_n;
            ok_flag_to_if  <= ok_if_n;
            ok_flag_to_lsb <= ok_lsb_n;
            inst_to_if     <= inst_n;
            data_to_lsb    <= data_lsb_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ena_from_if = 1'b0;
    logic [31:0] pc_from_if = 32'd0;
    logic        ok_flag_to_if;
    logic [31:0] inst_to_if;
    logic        ena_from_lsb = 1'b0;
    logic        wr_from_lsb = 1'b0;
    logic [31:0] addr_from_lsb = 32'd0;
    logic [1:0]  size_from_lsb = 2'd0;
    logic [31:0] data_from_lsb = 32'd0;
    logic        ok_flag_to_lsb;
    logic [31:0] data_to_lsb;
    logic        rollback = 1'b0;

    logic [7:0]  ram [0:1023];
    int          vectors = 0;
    int          miscompares = 0;
    logic        seen_ok;

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .ena_from_if    (ena_from_if),
        .pc_from_if     (pc_from_if),
        .ok_flag_to_if  (ok_flag_to_if),
        .inst_to_if     (inst_to_if),
        .ena_from_lsb   (ena_from_lsb),
        .wr_from_lsb    (wr_from_lsb),
        .addr_from_lsb  (addr_from_lsb),
        .size_from_lsb  (size_from_lsb),
        .data_from_lsb  (data_from_lsb),
        .ok_flag_to_lsb (ok_flag_to_lsb),
        .data_to_lsb    (data_to_lsb),
        .rollback       (rollback)
    );

    always #5 clk = ~clk;

    // synchronous RAM, one cycle read latency, frozen together with the rest of the system by rdy
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr)
                ram[mem_a[9:0]] <= mem_dout;
            mem_din <= ram[mem_a[9:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_if(input logic [31:0] pc);
        ena_from_if = 1'b1;
        pc_from_if  = pc;
        tick();
        ena_from_if = 1'b0;
    endtask

    task automatic pulse_lsb(input logic wr, input logic [31:0] addr,
                             input logic [1:0] size, input logic [31:0] data);
        ena_from_lsb  = 1'b1;
        wr_from_lsb   = wr;
        addr_from_lsb = addr;
        size_from_lsb = size;
        data_from_lsb = data;
        tick();
        ena_from_lsb  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[4] = 8'h13; ram[5] = 8'h05; ram[6] = 8'h00; ram[7] = 8'h00;
        ram[256] = 8'hFF;

        tick(); tick();
        chk("rst_mem_a",   mem_a, 32'd0);
        chk("rst_mem_wr",  32'(mem_wr), 32'd0);
        chk("rst_ok_if",   32'(ok_flag_to_if), 32'd0);
        chk("rst_ok_lsb",  32'(ok_flag_to_lsb), 32'd0);
        chk("rst_inst",    inst_to_if, 32'd0);
        rst = 1'b1;
        tick();

        // IF word read at 0x4
        pulse_if(32'h4);
        chk("if_a0", mem_a, 32'h4);
        chk("if_wr0", 32'(mem_wr), 32'd0);
        tick(); chk("if_a1", mem_a, 32'h5);
        tick(); chk("if_a2", mem_a, 32'h6);
        tick(); chk("if_a3", mem_a, 32'h7);
        tick(); chk("if_ok_e4", 32'(ok_flag_to_if), 32'd0);
        tick(); chk("if_ok_e5", 32'(ok_flag_to_if), 32'd1);
        chk("if_inst", inst_to_if, 32'h00000513);
        tick(); chk("if_ok_e6", 32'(ok_flag_to_if), 32'd0);
        chk("if_inst_hold", inst_to_if, 32'h00000513);

        // simultaneous IF and LSB byte read: LSB first
        ena_from_if = 1'b1;
        pc_from_if  = 32'h4;
        pulse_lsb(1'b0, 32'h100, 2'b00, 32'd0);
        ena_from_if = 1'b0;
        chk("arb_a0", mem_a, 32'h100);
        tick(); chk("arb_ok_e1", 32'(ok_flag_to_lsb), 32'd0);
        tick(); chk("arb_ok_e2", 32'(ok_flag_to_lsb), 32'd1);
        chk("arb_data", data_to_lsb, 32'h000000FF);
        chk("arb_a_e2", mem_a, 32'h100);
        tick(); chk("arb_if_start", mem_a, 32'h4);
        chk("arb_ok_e3", 32'(ok_flag_to_lsb), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("arb_if_ok", 32'(ok_flag_to_if), 32'd1);
        chk("arb_if_inst", inst_to_if, 32'h00000513);

        // 4 B store of 0xDEADBEEF to 0x200
        pulse_lsb(1'b1, 32'h200, 2'b10, 32'hDEADBEEF);
        chk("wr_a0", mem_a, 32'h200); chk("wr_d0", 32'(mem_dout), 32'hEF);
        chk("wr_w0", 32'(mem_wr), 32'd1);
        tick(); chk("wr_a1", mem_a, 32'h201); chk("wr_d1", 32'(mem_dout), 32'hBE);
        tick(); chk("wr_a2", mem_a, 32'h202); chk("wr_d2", 32'(mem_dout), 32'hAD);
        tick(); chk("wr_a3", mem_a, 32'h203); chk("wr_d3", 32'(mem_dout), 32'hDE);
        chk("wr_w3", 32'(mem_wr), 32'd1);
        tick(); chk("wr_ok", 32'(ok_flag_to_lsb), 32'd1);
        chk("wr_w4", 32'(mem_wr), 32'd0);
        chk("wr_ram", {ram[515], ram[514], ram[513], ram[512]}, 32'hDEADBEEF);
        tick(); chk("wr_ok_e5", 32'(ok_flag_to_lsb), 32'd0);

        // IO store stalled by a full output buffer for three edges
        io_buffer_full = 1'b1;
        pulse_lsb(1'b1, 32'h30000, 2'b00, 32'h5A);
        chk("io_stall0", 32'(mem_wr), 32'd0);
        tick(); chk("io_stall1", 32'(mem_wr), 32'd0);
        tick(); chk("io_stall2", 32'(mem_wr), 32'd0);
        io_buffer_full = 1'b0;
        tick(); chk("io_go_wr", 32'(mem_wr), 32'd1);
        chk("io_go_a", mem_a, 32'h30000);
        chk("io_go_d", 32'(mem_dout), 32'h5A);
        tick(); chk("io_ok", 32'(ok_flag_to_lsb), 32'd1);

        // rollback at E3 of a fetch
        pulse_if(32'h4);
        tick(); tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        seen_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen_ok = seen_ok | ok_flag_to_if;
            tick();
        end
        chk("rb_no_ok", 32'(seen_ok), 32'd0);
        pulse_lsb(1'b0, 32'h100, 2'b00, 32'd0);
        chk("rb_idle", mem_a, 32'h100);
        tick(); tick();
        chk("rb_lsb_ok", 32'(ok_flag_to_lsb), 32'd1);

        // rollback during a 4 B store
        pulse_lsb(1'b1, 32'h204, 2'b10, 32'h11223344);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        chk("rbw_a1", mem_a, 32'h205); chk("rbw_d1", 32'(mem_dout), 32'h33);
        tick(); tick(); tick();
        chk("rbw_ok", 32'(ok_flag_to_lsb), 32'd1);
        chk("rbw_ram", {ram[519], ram[518], ram[517], ram[516]}, 32'h11223344);

        // rdy low for two cycles mid-read
        pulse_if(32'h4);
        tick();
        rdy = 1'b0;
        tick(); tick();
        chk("rdy_frozen_a", mem_a, 32'h5);
        rdy = 1'b1;
        tick(); tick(); tick();
        chk("rdy_ok_e6", 32'(ok_flag_to_if), 32'd0);
        tick();
        chk("rdy_ok_e7", 32'(ok_flag_to_if), 32'd1);
        chk("rdy_inst", inst_to_if, 32'h00000513);

        // asynchronous reset mid-read
        pulse_if(32'h4);
        tick(); tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_mem_a", mem_a, 32'd0);
        chk("ar_mem_dout", 32'(mem_dout), 32'd0);
        chk("ar_inst", inst_to_if, 32'd0);
        chk("ar_data_lsb", data_to_lsb, 32'd0);
        chk("ar_ok_if", 32'(ok_flag_to_if), 32'd0);
        tick(); tick();
        rst = 1'b1;
        seen_ok = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            seen_ok = seen_ok | ok_flag_to_if;
        end
        chk("ar_no_ok", 32'(seen_ok), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
